fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- IF-stage fetch unit for the P6 pipelined MIPS core: the consumer of the next-PC value the ID stage computes.
- Owns the PC register and the instruction-memory request handshake.
- Owns the IF/ID pipeline register, including delay-slot ordering and redirect buffering.
- Sits between the hazard unit and ID-stage next-PC logic on one side, and instruction memory on the other.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID for bubbles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_Stall  in  1  hazard unit: hold PC and IF/ID.
- i_Redirect  in  1  ID next-PC logic: the branch/jump in ID is taken; qualified by !i_Stall.
- i_nPC  in  32  redirect target; valid with i_Redirect.
- o_ImReq  out  1  instruction-memory request.
- o_ImAddr  out  32  word address of the request.
- i_ImAck  in  1  memory has returned data; may arrive the same cycle as o_ImReq or later.
- i_ImData  in  32  instruction word; valid with i_ImAck.
- o_IF_ID_Instr  out  32  IF/ID instruction.
- o_IF_ID_PC  out  32  PC of o_IF_ID_Instr.
- o_IF_ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- o_IF_ID_AdEL  out  1  fetch address error (see Optional Feature).
- o_PC  out  32  current fetch PC (debug).

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-high.
- Reset values: PC=RESET_PC, state=S_FETCH, pend=0, pend_target=0, hold_data=0, o_IF_ID_Instr=NOP_INSTR, o_IF_ID_PC=0, o_IF_ID_Valid=0, o_IF_ID_AdEL=0.
- Reset mid-operation: outstanding requests are abandoned. Any ack arriving after reset deassertion without a new request is ignored.
- o_ImReq=1 only in S_FETCH and not during reset. o_ImAddr=PC. PC is stable until ack, so the address never changes mid-request.
- Next PC, in priority order:
  - pend ? pend_target
  - else (i_Redirect & !i_Stall) ? i_nPC
  - else PC+4 (mod 2^32).
  - The redirect takes effect after the delay slot, which is the instruction at the current PC; that instruction is always delivered.
- State S_FETCH:
  - ack & !stall: IF/ID <= {i_ImData, PC, valid=1}; PC <= next; pend <= 0. Latency ack->IF/ID = 1 edge.
  - ack & stall: hold_data <= i_ImData; go S_HOLD; IF/ID unchanged.
  - !ack & !stall: IF/ID <= bubble {NOP_INSTR, PC, valid=0}.
  - !ack & stall: IF/ID unchanged.
- State S_HOLD:
  - o_ImReq=0. Any ack received here is ignored.
  - !stall: IF/ID <= {hold_data, PC, 1}; PC <= next; pend <= 0; go S_FETCH.
- Redirect buffering:
  - A qualified i_Redirect not consumed in the same cycle sets pend=1 and pend_target=i_nPC.
  - "Not consumed" means no IF/ID load of the delay slot that cycle.
  - A second redirect while pend=1 is architecturally impossible. The RTL must still behave deterministically (latest target wins), and the bench flags it as an error.
- Simultaneous ack and redirect in the same cycle: the redirect is consumed directly, so PC <= i_nPC.
- i_Redirect while i_Stall=1 is ignored.
- Boundary: PC=32'hFFFF_FFFC with no redirect wraps to 0.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Enabled:
  - If PC[1:0]!=0 in S_FETCH, no request is issued.
  - On the next !stall edge, IF/ID <= {NOP_INSTR, PC, valid=1, AdEL=1}, then PC <= next.
  - o_IF_ID_AdEL clears on the next IF/ID load.
- Disabled:
  - o_ImAddr = {PC[31:2], 2'b00}.
  - o_IF_ID_AdEL is tied to 0; the port is kept so the interface stays stable.

Decomposition:
- macro.v gets the following, alongside the existing NPC mode constants:
  - `FETCH_S_FETCH / `FETCH_S_HOLD state encodings.
  - `RESET_PC_DEFAULT.
  - `NOP_INSTR.
- One natural sub-module: if_id_reg, the IF/ID register with load/bubble/hold controls. The FSM, PC and pending-redirect logic stay in fetch_unit.

Test Plan:
1. Reset, then zero-wait memory (ack = req), no stall, 4 cycles -> IF/ID PCs 3000, 3004, 3008, 300C; all valid=1; o_PC=3010.
2. Memory acks PC 3008 after 3 cycles -> 2 bubbles (valid=0, PC=3008); PC and o_ImAddr held at 3008 throughout; then valid instr at 3008.
3. Branch at 3004 in ID asserts i_Redirect with i_nPC=3100 while the delay slot 3008 is still waiting for ack -> pend=1; delay slot 3008 delivered; next request address is 3100.
4. Ack at 300C while i_Stall=1 for 2 cycles -> IF/ID unchanged, o_ImReq=0 during S_HOLD; on release IF/ID={data, 300C, 1} and PC=3010.
5. Assert reset in S_HOLD with pend=1 -> outputs return immediately to reset values; first post-reset request is address 3000.
6. FETCH_ALIGN_CHECK_EN defined, redirect to 3102 -> no request issued for 3102; IF/ID={NOP_INSTR, 3102, valid=1, AdEL=1}; next fetch at 3106.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the IF-stage fetch unit.
// Optional feature macro used by the fetch unit: FETCH_ALIGN_CHECK_EN.
package fetch_unit_pkg;

    // PC loaded on reset and the instruction word used for IF/ID bubbles.
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // S_FETCH: request outstanding (or being issued) for the current PC.
    // S_HOLD : data already returned, parked until the stall releases.
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } if_id_t;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request channel between the fetch unit
// (master) and instruction memory (slave).
//
// Handshake: o_ImReq is a request level; while it is high o_ImAddr is stable.
// The transfer completes on the first rising edge where o_ImReq and i_ImAck
// are both high; i_ImData is valid only in that cycle. i_ImAck seen while
// o_ImReq is low carries no meaning and is ignored by the master.
interface fetch_unit_if;
    logic        o_ImReq;
    logic [31:0] o_ImAddr;
    logic        i_ImAck;
    logic [31:0] i_ImData;

    modport master (
        output o_ImReq,
        output o_ImAddr,
        input  i_ImAck,
        input  i_ImData
    );

    modport slave (
        input  o_ImReq,
        input  o_ImAddr,
        output i_ImAck,
        output i_ImData
    );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// fetch_unit_if_id_reg: IF/ID pipeline register with load, bubble and hold.
// load has priority over bubble; with neither asserted the register holds.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] bubble_pc,
    input  if_id_t      d,
    output if_id_t      q
);

    // Pipeline register update: full load, bubble insertion, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q.instr <= NOP_INSTR;
            q.pc    <= '0;
            q.valid <= 1'b0;
            q.adel  <= 1'b0;
        end else if (load) begin
            q <= d;
        end else if (bubble) begin
            q.instr <= NOP_INSTR;
            q.pc    <= bubble_pc;
            q.valid <= 1'b0;
            q.adel  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the pipelined MIPS core. Owns the PC, the
// instruction-memory request, the IF/ID register and the buffering of a
// redirect that arrives before its delay slot has been delivered.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned PC raises AdEL
// instead of issuing a request). Default build: address low bits masked.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_Stall,
    input  logic         i_Redirect,
    input  logic [31:0]  i_nPC,
    fetch_unit_if.master im,
    output logic [31:0]  o_IF_ID_Instr,
    output logic [31:0]  o_IF_ID_PC,
    output logic         o_IF_ID_Valid,
    output logic         o_IF_ID_AdEL,
    output logic [31:0]  o_PC,
    output fetch_state_e o_State
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         pend;
    logic [31:0]  pend_target;
    logic [31:0]  hold_data;

    logic         misaligned;
    logic         redirect_q;
    logic         ack_fetch;
    logic         deliver_mem;
    logic         deliver_hold;
    logic         deliver_adel;
    logic         advance;
    logic         bubble;
    logic [31:0]  next_pc;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned PC never reaches memory; it turns into an AdEL slot.
    assign misaligned  = (pc[1:0] != 2'b00);
    assign im.o_ImAddr = pc;
`else
    // Without the check the low address bits are simply dropped.
    assign misaligned  = 1'b0;
    assign im.o_ImAddr = {pc[31:2], 2'b00};
`endif

    // PC only moves when the IF/ID register loads, so the address is stable
    // for the whole life of a request.
    assign im.o_ImReq = (state == S_FETCH) && !misaligned && !reset;

    // A redirect only counts when the pipeline is moving.
    assign redirect_q   = i_Redirect && !i_Stall;
    assign ack_fetch    = (state == S_FETCH) && !misaligned && im.i_ImAck;
    assign deliver_mem  = ack_fetch && !i_Stall;
    assign deliver_hold = (state == S_HOLD) && !i_Stall;
    assign deliver_adel = (state == S_FETCH) && misaligned && !i_Stall;
    assign advance      = deliver_mem || deliver_hold || deliver_adel;
    assign bubble       = (state == S_FETCH) && !misaligned && !im.i_ImAck && !i_Stall;

    // Buffered target first (its delay slot is the one being delivered now),
    // then a same-cycle redirect, then sequential flow.
    assign next_pc = pend       ? pend_target :
                     redirect_q ? i_nPC       :
                                  pc_plus4(pc);

    // Select the word loaded into IF/ID for whichever delivery is happening.
    always_comb begin
        if_id_d.instr = NOP_INSTR;
        if_id_d.pc    = pc;
        if_id_d.valid = 1'b1;
        if_id_d.adel  = 1'b0;
        if (deliver_mem) begin
            if_id_d.instr = im.i_ImData;
        end else if (deliver_hold) begin
            if_id_d.instr = hold_data;
        end else if (deliver_adel) begin
            if_id_d.adel  = 1'b1;
        end
    end

    // Fetch FSM, PC and pending-redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_target <= '0;
            hold_data   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (ack_fetch && i_Stall) begin
                        hold_data <= im.i_ImData;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!i_Stall) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase

            if (advance) begin
                pc   <= next_pc;
                pend <= 1'b0;
            end else if (redirect_q) begin
                // Delay slot not delivered yet: remember the target. A second
                // redirect here is not expected; the latest one wins.
                pend        <= 1'b1;
                pend_target <= i_nPC;
            end
        end
    end

    fetch_unit_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (advance),
        .bubble    (bubble),
        .bubble_pc (pc),
        .d         (if_id_d),
        .q         (if_id_q)
    );

    assign o_IF_ID_Instr = if_id_q.instr;
    assign o_IF_ID_PC    = if_id_q.pc;
    assign o_IF_ID_Valid = if_id_q.valid;
    assign o_IF_ID_AdEL  = if_id_q.adel;
    assign o_PC          = pc;
    assign o_State       = state;

endmodule
